data_mem_ctrl: RTL and testbench

- Next-generation data memory unit for the RV32I pipeline's MEM stage.
- Adds a valid/ready request/response handshake and a parametrised read latency.
- Adds error detection for misaligned, illegal-func3 and out-of-range accesses.
- Contains its own word-organised byte-writable RAM, store byte-lane steering and load sign/zero extension.
- The pipeline stalls MEM on req_ready low.

---
 rtl/data_mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory for RV32I: valid/ready request/response, parametrised read latency,
// access error detection, byte-writable word RAM, store lane steering and load extension.
module data_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned IW    = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 2 ** IW;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        ld_q, ld_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

  logic [31:0] mem    [DEPTH];
  logic [31:0] pipe_q [RD_LATENCY];

  logic          accept;
  logic          req_err;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [IW-1:0] widx;
  logic [31:0]   word;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic [31:0]   fmt;

  assign accept = req_valid && (state_q == IDLE);
  assign widx   = req_addr[ADDR_WIDTH-1:2];

  always_comb begin
    req_err = 1'b0;
    case (req_func3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = |req_addr[1:0];
      3'b100:  req_err = req_we;
      3'b101:  req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
    if (|req_addr[31:ADDR_WIDTH]) req_err = 1'b1;
  end

  always_comb begin
    be    = '0;
    wlane = req_wdata;
    case (req_func3[1:0])
      2'b00: begin
        be    = 4'b0001 << req_addr[1:0];
        wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{req_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // A store on an edge with rst high is suppressed, not just the FSM update.
  always_ff @(posedge clk) begin
    if (!rst && accept && req_we && !req_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  // Stage 0 samples the RAM on the accepting edge; the pipe freezes in RESP to hold data stable.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) pipe_q[0] <= mem[widx];
    if (state_q != RESP) begin
      for (int unsigned i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ld_d    = ld_q;
    f3_d    = f3_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          err_d   = req_err;
          ld_d    = !req_we && !req_err;
          f3_d    = req_func3;
          off_d   = req_addr[1:0];
          cnt_d   = 3'(RD_LATENCY - 1);
          state_d = (ld_d && (RD_LATENCY > 1)) ? RD_WAIT : RESP;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  assign word = pipe_q[RD_LATENCY-1];
  assign bsel = word[{off_q, 3'b000} +: 8];
  assign hsel = off_q[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  fmt = {{24{bsel[7]}}, bsel};
      3'b001:  fmt = {{16{hsel[15]}}, hsel};
      3'b100:  fmt = {24'd0, bsel};
      3'b101:  fmt = {16'd0, hsel};
      default: fmt = word;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && ld_q) ? fmt : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with RD_LATENCY=1, one with RD_LATENCY=3.
module tb_data_mem_ctrl;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [2:0]  req_func3 [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WIDTH(10), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_func3(req_func3[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  data_mem_ctrl #(.ADDR_WIDTH(10), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_func3(req_func3[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_func3[d] = f3;
  endtask

  // Issues one request from IDLE, waits (bounded) for the response, then completes it.
  task automatic txn(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] f3, output logic [31:0] rdata, output logic err, output int lat);
    drive(d, we, addr, wdata, f3);
    tick();
    req_valid[d] = 1'b0;
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    rsp_ready[d] = 1'b1;
    tick();
    rsp_ready[d] = 1'b0;
  endtask

  task automatic st(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [2:0] f3, input string tag);
    logic [31:0] rd; logic e; int lat;
    txn(d, 1'b1, addr, wdata, f3, rd, e, lat);
    check({tag, ".lat"}, 32'(lat), 32'd1);
    check({tag, ".err"}, {31'd0, e}, 32'd0);
    check({tag, ".rdata"}, rd, 32'd0);
  endtask

  task automatic ld(input int d, input logic [31:0] addr, input logic [2:0] f3,
                    input logic [31:0] exp, input int exp_lat, input string tag);
    logic [31:0] rd; logic e; int lat;
    txn(d, 1'b0, addr, 32'd0, f3, rd, e, lat);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".err"}, {31'd0, e}, 32'd0);
    check({tag, ".rdata"}, rd, exp);
  endtask

  task automatic bad(input int d, input logic we, input logic [31:0] addr,
                     input logic [2:0] f3, input string tag);
    logic [31:0] rd; logic e; int lat;
    txn(d, we, addr, 32'hFFFF_FFFF, f3, rd, e, lat);
    check({tag, ".lat"}, 32'(lat), 32'd1);
    check({tag, ".err"}, {31'd0, e}, 32'd1);
    check({tag, ".rdata"}, rd, 32'd0);
  endtask

  task automatic idle_chk(input int d, input string tag);
    check({tag, ".rsp_valid"}, {31'd0, rsp_valid[d]}, 32'd0);
    check({tag, ".rsp_rdata"}, rsp_rdata[d], 32'd0);
    check({tag, ".rsp_err"}, {31'd0, rsp_err[d]}, 32'd0);
    check({tag, ".busy"}, {31'd0, busy[d]}, 32'd0);
    check({tag, ".req_ready"}, {31'd0, req_ready[d]}, 32'd1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   req_func3[d] = '0; rsp_ready[d] = 1'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle_chk(0, "rst1");
    idle_chk(1, "rst3");

    // Latency 1: basic store/load and formatting.
    st(0, 32'h10, 32'hDEAD_BEEF, F_W, "sw10");
    ld(0, 32'h10, F_W, 32'hDEAD_BEEF, 1, "lw10");
    st(0, 32'h13, 32'h0000_0080, F_B, "sb13");
    ld(0, 32'h13, F_B,  32'hFFFF_FF80, 1, "lb13");
    ld(0, 32'h13, F_BU, 32'h0000_0080, 1, "lbu13");
    ld(0, 32'h12, F_H,  32'hFFFF_80AD, 1, "lh12");
    ld(0, 32'h10, F_B,  32'hFFFF_FFEF, 1, "lb10");
    ld(0, 32'h10, F_HU, 32'h0000_BEEF, 1, "lhu10");

    // Rejected accesses leave the RAM untouched.
    bad(0, 1'b0, 32'h11, F_H, "lh11");
    bad(0, 1'b0, 32'h12, F_W, "lw12");
    bad(0, 1'b0, 32'h10, 3'b011, "f3_011");
    bad(0, 1'b0, 32'h10, 3'b110, "f3_110");
    bad(0, 1'b0, 32'h0001_0000, F_W, "lw_oor");
    bad(0, 1'b1, 32'h12, F_W, "sw12");
    bad(0, 1'b1, 32'h11, F_H, "sh11");
    bad(0, 1'b1, 32'h10, F_BU, "sbu10");
    bad(0, 1'b1, 32'h0001_0010, F_W, "sw_oor");
    ld(0, 32'h10, F_W, 32'h80AD_BEEF, 1, "lw10_after_err");
    st(0, 32'h0, 32'h0BAD_F00D, F_W, "sw0");
    bad(0, 1'b1, 32'h400, F_W, "sw400");
    ld(0, 32'h0, F_W, 32'h0BAD_F00D, 1, "lw0_after_err");

    // Halfword/byte lane steering.
    st(0, 32'h14, 32'h0000_0000, F_W, "sw14");
    st(0, 32'h16, 32'h1234_A5C3, F_H, "sh16");
    st(0, 32'h15, 32'hFFFF_FF7F, F_B, "sb15");
    ld(0, 32'h14, F_W,  32'hA5C3_7F00, 1, "lw14");
    ld(0, 32'h16, F_H,  32'hFFFF_A5C3, 1, "lh16");
    ld(0, 32'h16, F_HU, 32'h0000_A5C3, 1, "lhu16");
    ld(0, 32'h15, F_B,  32'h0000_007F, 1, "lb15");
    ld(0, 32'h14, F_BU, 32'h0000_0000, 1, "lbu14");

    // Store coinciding with reset must not write.
    st(0, 32'h20, 32'h1111_1111, F_W, "sw20");
    drive(0, 1'b1, 32'h20, 32'h2222_2222, F_W);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid[0] = 1'b0;
    check("rstst.rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("rstst.req_ready", {31'd0, req_ready[0]}, 32'd1);
    ld(0, 32'h20, F_W, 32'h1111_1111, 1, "lw20_after_rst");

    // Back-to-back with rsp_ready tied high: one transaction every two cycles.
    rsp_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, w;
      a = 32'h100 + 32'(4 * i);
      w = 32'h0101_0101 * 32'(i + 1);
      drive(0, 1'b1, a, w, F_W);
      tick();
      check("b2b.st_valid", {31'd0, rsp_valid[0]}, 32'd1);
      check("b2b.st_ready", {31'd0, req_ready[0]}, 32'd0);
      drive(0, 1'b0, a, 32'd0, F_W);
      tick();
      check("b2b.idle_ready", {31'd0, req_ready[0]}, 32'd1);
      tick();
      check("b2b.ld_valid", {31'd0, rsp_valid[0]}, 32'd1);
      check("b2b.ld_rdata", rsp_rdata[0], w);
      req_valid[0] = 1'b0;
      tick();
      check("b2b.ld_done", {31'd0, rsp_valid[0]}, 32'd0);
    end
    rsp_ready[0] = 1'b0;

    // Latency 3 with a stalled consumer and a competing request.
    st(1, 32'h40, 32'hCAFE_F00D, F_W, "l3.sw40");
    drive(1, 1'b0, 32'h40, 32'd0, F_W);
    tick();
    req_valid[1] = 1'b0;
    check("l3.c1_valid", {31'd0, rsp_valid[1]}, 32'd0);
    check("l3.c1_busy", {31'd0, busy[1]}, 32'd1);
    check("l3.c1_ready", {31'd0, req_ready[1]}, 32'd0);
    tick();
    check("l3.c2_valid", {31'd0, rsp_valid[1]}, 32'd0);
    tick();
    check("l3.c3_valid", {31'd0, rsp_valid[1]}, 32'd1);
    check("l3.c3_rdata", rsp_rdata[1], 32'hCAFE_F00D);
    drive(1, 1'b1, 32'h40, 32'h5555_5555, F_W);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("l3.hold_valid", {31'd0, rsp_valid[1]}, 32'd1);
      check("l3.hold_rdata", rsp_rdata[1], 32'hCAFE_F00D);
      check("l3.hold_ready", {31'd0, req_ready[1]}, 32'd0);
    end
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;
    check("l3.hs_valid", {31'd0, rsp_valid[1]}, 32'd0);
    check("l3.hs_ready", {31'd0, req_ready[1]}, 32'd1);
    tick();
    req_valid[1] = 1'b0;
    check("l3.st2_valid", {31'd0, rsp_valid[1]}, 32'd1);
    check("l3.st2_err", {31'd0, rsp_err[1]}, 32'd0);
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;
    ld(1, 32'h40, F_W, 32'h5555_5555, 3, "l3.lw40");
    st(1, 32'h44, 32'h8000_7FFF, F_W, "l3.sw44");
    ld(1, 32'h44, F_H,  32'h0000_7FFF, 3, "l3.lh44");
    ld(1, 32'h46, F_H,  32'hFFFF_8000, 3, "l3.lh46");
    ld(1, 32'h47, F_BU, 32'h0000_0080, 3, "l3.lbu47");
    bad(1, 1'b0, 32'h42, F_W, "l3.lw42");

    // Reset during RD_WAIT aborts the load.
    drive(1, 1'b0, 32'h40, 32'd0, F_W);
    tick();
    req_valid[1] = 1'b0;
    check("l3.rdwait_busy", {31'd0, busy[1]}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_chk(1, "l3.abort");
    tick();
    tick();
    tick();
    check("l3.abort_late", {31'd0, rsp_valid[1]}, 32'd0);
    ld(1, 32'h40, F_W, 32'h5555_5555, 3, "l3.lw40_post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
